// File: rtl/fp_pkg.sv
// Shared constants for the pipelined floating-point adder/subtractor.
package fp_pkg;

   localparam int FLAG_OVF   = 0;
   localparam int FLAG_UNF   = 1;
   localparam int FP_ADD_LAT = 3;
   localparam int GRS_W      = 3;

   typedef logic [1:0] fp_flags_t;

endpackage

// File: rtl/fp_norm_lzc.sv
// Leading-zero counter used by the normalisation stage; an all-zero input yields WIDTH.
module fp_norm_lzc #(
   parameter  int WIDTH = 9,
   localparam int CW    = $clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0] din_i,
   output logic [CW-1:0]    cnt_o
);

   // Scanning upward lets the highest set bit make the final assignment.
   always_comb begin
      cnt_o = CW'(WIDTH);
      for (int i = 0; i < WIDTH; i++) begin
         if (din_i[i]) cnt_o = CW'(WIDTH - 1 - i);
      end
   end

endmodule

// File: rtl/fp_addsub_pipe.sv
// Three-stage floating-point add/sub with valid/ready handshake and overflow/underflow flags.
// Define FP_ADDSUB_RNE_EN for round-to-nearest-even; otherwise results are truncated.
module fp_addsub_pipe
   import fp_pkg::*;
#(
   parameter  int EXP_W = 4,
   parameter  int MAN_W = 7,
   localparam int W     = 1 + EXP_W + MAN_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_x,
   input  logic [W-1:0] in_y,
   input  logic         in_sub,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_result,
   output logic [1:0]   out_flags
);

   localparam int MW = MAN_W + 1;
   localparam int XW = MW + GRS_W;
   localparam int SW = XW + 1;
   localparam int LW = MAN_W + 2;
   localparam int CW = $clog2(LW + 1);
   localparam int EW = EXP_W + 2;
   localparam logic [EW-1:0] EMAX_E = EW'((2 ** EXP_W) - 1);

   logic adv;
   logic s1_valid_q, s2_valid_q, out_valid_q;

   assign adv       = !out_valid_q || out_ready;
   assign in_ready  = adv;
   assign out_valid = out_valid_q;

   // Stage 1: apply operation to Y's sign, order operands by magnitude.
   logic [W-1:0]     y_eff, p_w, q_w;
   logic             swap;
   logic             s1_sign_q, s1_sub_q;
   logic [EXP_W-1:0] s1_pe_q, s1_qe_q, s1_diff_q;
   logic [MAN_W-1:0] s1_pf_q, s1_qf_q;

   assign y_eff = {in_y[W-1] ^ in_sub, in_y[W-2:0]};
   assign swap  = in_y[W-2:0] > in_x[W-2:0];
   assign p_w   = swap ? y_eff : in_x;
   assign q_w   = swap ? in_x : y_eff;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_sign_q  <= 1'b0;
         s1_sub_q   <= 1'b0;
         s1_pe_q    <= '0;
         s1_qe_q    <= '0;
         s1_diff_q  <= '0;
         s1_pf_q    <= '0;
         s1_qf_q    <= '0;
      end else if (adv) begin
         s1_valid_q <= in_valid;
         if (in_valid) begin
            s1_sign_q <= p_w[W-1];
            s1_sub_q  <= p_w[W-1] ^ q_w[W-1];
            s1_pe_q   <= p_w[W-2:MAN_W];
            s1_qe_q   <= q_w[W-2:MAN_W];
            s1_diff_q <= p_w[W-2:MAN_W] - q_w[W-2:MAN_W];
            s1_pf_q   <= p_w[MAN_W-1:0];
            s1_qf_q   <= q_w[MAN_W-1:0];
         end
      end
   end

   // Stage 2: align Q with sticky collection, then add or subtract.
   logic [XW-1:0]    p_ext, q_ext, q_al;
   logic             sticky;
   logic [SW-1:0]    sum_d, s2_sum_q;
   logic [EXP_W-1:0] s2_exp_q;
   logic             s2_sign_q;

   assign p_ext = (s1_pe_q == '0) ? '0 : {1'b1, s1_pf_q, {GRS_W{1'b0}}};
   assign q_ext = (s1_qe_q == '0) ? '0 : {1'b1, s1_qf_q, {GRS_W{1'b0}}};

   always_comb begin
      sticky = 1'b0;
      for (int i = 0; i < XW; i++) begin
         if (i < int'(s1_diff_q)) sticky = sticky | q_ext[i];
      end
      if (int'(s1_diff_q) >= XW) begin
         q_al = {{(XW-1){1'b0}}, |q_ext};
      end else begin
         q_al    = q_ext >> s1_diff_q;
         q_al[0] = q_al[0] | sticky;
      end
   end

   assign sum_d = s1_sub_q ? ({1'b0, p_ext} - {1'b0, q_al})
                           : ({1'b0, p_ext} + {1'b0, q_al});

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid_q <= 1'b0;
         s2_sum_q   <= '0;
         s2_exp_q   <= '0;
         s2_sign_q  <= 1'b0;
      end else if (adv) begin
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            s2_sum_q  <= sum_d;
            s2_exp_q  <= s1_pe_q;
            s2_sign_q <= s1_sign_q;
         end
      end
   end

   // Stage 3: normalise, round, classify. The LZC window is mantissa plus guard:
   // deep cancellation only happens for diff<=1, where round/sticky are zero.
   logic [CW-1:0] lz;
   logic [XW-1:0] norm;
   logic [EW-1:0] exp_n, exp_r;
   logic [MW-1:0] mant, mant_f;
   logic [MW:0]   mant_r;
   logic          rnd_up, ovf, unf;
   logic [W-1:0]  res_d, out_result_q;
   fp_flags_t     flags_d, out_flags_q;

   fp_norm_lzc #(.WIDTH(LW)) u_lzc (
      .din_i (s2_sum_q[SW-2:GRS_W-1]),
      .cnt_o (lz)
   );

   always_comb begin
      if (s2_sum_q[SW-1]) begin
         norm    = s2_sum_q[SW-1:1];
         norm[0] = norm[0] | s2_sum_q[0];
         exp_n   = {2'b00, s2_exp_q} + EW'(1);
      end else begin
         norm  = s2_sum_q[XW-1:0] << lz;
         exp_n = {2'b00, s2_exp_q} - EW'(lz);
      end
   end

   assign mant = norm[XW-1:GRS_W];
`ifdef FP_ADDSUB_RNE_EN
   assign rnd_up = norm[GRS_W-1] & ((|norm[GRS_W-2:0]) | norm[GRS_W]);
`else
   assign rnd_up = 1'b0;
`endif
   assign mant_r = {1'b0, mant} + {{MW{1'b0}}, rnd_up};

   always_comb begin
      if (mant_r[MW]) begin
         mant_f = mant_r[MW:1];
         exp_r  = exp_n + EW'(1);
      end else begin
         mant_f = mant_r[MW-1:0];
         exp_r  = exp_n;
      end
   end

   assign ovf = !exp_r[EW-1] && (exp_r >= EMAX_E);
   assign unf = exp_r[EW-1] || (exp_r == '0);

   always_comb begin
      flags_d = '0;
      if (s2_sum_q == '0) begin
         res_d = '0;
      end else if (ovf) begin
         res_d             = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         flags_d[FLAG_OVF] = 1'b1;
      end else if (unf) begin
         res_d             = {s2_sign_q, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
         flags_d[FLAG_UNF] = 1'b1;
      end else begin
         res_d = {s2_sign_q, exp_r[EXP_W-1:0], mant_f[MAN_W-1:0]};
      end
   end

   logic unused_bits;
`ifdef FP_ADDSUB_RNE_EN
   assign unused_bits = mant_f[MAN_W];
`else
   assign unused_bits = ^{mant_f[MAN_W], norm[GRS_W-1:0]};
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q  <= 1'b0;
         out_result_q <= '0;
         out_flags_q  <= '0;
      end else if (adv) begin
         out_valid_q <= s2_valid_q;
         if (s2_valid_q) begin
            out_result_q <= res_d;
            out_flags_q  <= flags_d;
         end
      end
   end

   assign out_result = out_result_q;
   assign out_flags  = out_flags_q;

endmodule
